// File: rtl/dec3_to_bin_seq_pkg.sv
// dec3_to_bin_seq_pkg: shared state encoding and BCD adjust constant
package dec3_to_bin_seq_pkg;
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2} state_t;
   localparam logic [3:0] BCD_ADJ = 4'd3;
endpackage

// File: rtl/dec3_to_bin_seq_nibble_adj.sv
// bcd_nibble_adj: reverse double-dabble correction for one BCD nibble
module bcd_nibble_adj
   import dec3_to_bin_seq_pkg::*;
(
   input  logic [3:0] in,
   output logic [3:0] out
);
   assign out = (in >= 4'd8) ? in - BCD_ADJ : in;
endmodule

// File: rtl/dec3_to_bin_seq.sv
// dec3_to_bin_seq: iterative BCD-to-binary converter with valid/ready handshakes
module dec3_to_bin_seq
   import dec3_to_bin_seq_pkg::*;
#(
   parameter int DIGITS = 3,
   parameter int BIN_W  = 10
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [4*DIGITS-1:0] bcd_in,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [BIN_W-1:0]    bin_out,
   output logic                err_digit,
   output logic                err_ovf,
   output logic                busy
);
   localparam int BW = 4*DIGITS;
   localparam int W  = BW + BIN_W;
   localparam int CW = $clog2(BIN_W+1);
   state_t        state, state_nx;
   logic [W-1:0]  wr, shifted;
   logic [BW-1:0] adj;
   logic [CW-1:0] cnt;
   logic          bad, err_d;
   assign shifted = wr >> 1;
   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_nibble_adj u_adj (.in(shifted[BIN_W+4*g +: 4]), .out(adj[4*g +: 4]));
   end
   always_comb begin
      bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) bad = bad | (bcd_in[4*i +: 4] > 4'd9);
   end
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (in_valid) state_nx = bad ? S_DONE : S_SHIFT;
         S_SHIFT: if (cnt == CW'(BIN_W-1)) state_nx = S_DONE;
         S_DONE:  if (out_ready) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         wr    <= '0;
         cnt   <= '0;
         err_d <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == S_IDLE && in_valid) begin
            wr    <= {bcd_in, BIN_W'(0)};
            cnt   <= '0;
            err_d <= bad;
         end else if (state == S_SHIFT) begin
            wr  <= {adj, shifted[BIN_W-1:0]};
            cnt <= cnt + CW'(1);
         end
      end
   end
   assign in_ready  = state == S_IDLE;
   assign out_valid = state == S_DONE;
   assign busy      = state != S_IDLE;
   assign bin_out   = wr[BIN_W-1:0];
   assign err_digit = err_d;
   // a bad digit leaves the raw BCD in place, so the residual check is suppressed
   assign err_ovf   = out_valid & ~err_d & (|wr[W-1:BIN_W]);
endmodule

// File: tb/tb_dec3_to_bin_seq.sv
// tb_dec3_to_bin_seq: directed checks of the BCD-to-binary converter
module tb_dec3_to_bin_seq;
   logic        clk = 1'b0, rst = 1'b1;
   logic        in_valid = 1'b0, out_ready = 1'b1;
   logic [11:0] bcd_in = '0;
   logic        in_ready, out_valid, err_digit, err_ovf, busy;
   logic [9:0]  bin_out;
   logic        iv8 = 1'b0;
   logic [11:0] bcd8 = '0;
   logic        ir8, ov8, ed8, eo8, busy8;
   logic [7:0]  bin8;
   int          n_assert = 0, n_fail = 0, lat;

   always #5 clk = ~clk;

   dec3_to_bin_seq #(.DIGITS(3), .BIN_W(10)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .bcd_in(bcd_in),
      .out_valid(out_valid), .out_ready(out_ready), .bin_out(bin_out),
      .err_digit(err_digit), .err_ovf(err_ovf), .busy(busy));

   dec3_to_bin_seq #(.DIGITS(3), .BIN_W(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .bcd_in(bcd8),
      .out_valid(ov8), .out_ready(1'b1), .bin_out(bin8),
      .err_digit(ed8), .err_ovf(eo8), .busy(busy8));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // accept one value and wait for out_valid; lat = 1 is the cycle right after the accept edge
   task automatic start(input logic [11:0] b);
      chk("in_ready_before_accept", 32'(in_ready), 1);
      bcd_in = b;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 40) begin
         step();
         lat++;
      end
   endtask

   task automatic run(input string tag, input logic [11:0] b, input int exp_bin,
                      input int exp_dig, input int exp_lat);
      start(b);
      chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_out_valid"}, 32'(out_valid), 1);
      chk({tag, "_bin_out"}, 32'(bin_out), 32'(exp_bin));
      chk({tag, "_err_digit"}, 32'(err_digit), 32'(exp_dig));
      chk({tag, "_err_ovf"}, 32'(err_ovf), 0);
      step();
      chk({tag, "_back_idle"}, 32'(in_ready), 1);
   endtask

   task automatic run8(input string tag, input logic [11:0] b, input int exp_bin, input int exp_ovf);
      bcd8 = b;
      iv8 = 1'b1;
      step();
      iv8 = 1'b0;
      lat = 1;
      while (!ov8 && lat < 40) begin
         step();
         lat++;
      end
      chk({tag, "_out_valid"}, 32'(ov8), 1);
      chk({tag, "_bin_out"}, 32'(bin8), 32'(exp_bin));
      chk({tag, "_err_ovf"}, 32'(eo8), 32'(exp_ovf));
      chk({tag, "_err_digit"}, 32'(ed8), 0);
      step();
   endtask

   initial begin
      step();
      step();
      rst = 1'b0;
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_bin_out", 32'(bin_out), 0);
      chk("rst_err_digit", 32'(err_digit), 0);
      chk("rst_err_ovf", 32'(err_ovf), 0);
      chk("rst_busy", 32'(busy), 0);

      run("c255", 12'h255, 255, 0, 11);
      run("c999", 12'h999, 999, 0, 11);
      run("c000", 12'h000, 0, 0, 11);
      run("c1A3", 12'h1A3, 0, 1, 1);
      run("c007_after_err", 12'h007, 7, 0, 11);

      run8("w8_256", 12'h256, 8'h00, 1);
      run8("w8_255", 12'h255, 8'hFF, 0);

      out_ready = 1'b0;
      start(12'h042);
      chk("bp_latency", 32'(lat), 11);
      for (int i = 0; i < 5; i++) begin
         chk("bp_out_valid", 32'(out_valid), 1);
         chk("bp_bin_out", 32'(bin_out), 42);
         chk("bp_err_digit", 32'(err_digit), 0);
         chk("bp_err_ovf", 32'(err_ovf), 0);
         chk("bp_in_ready", 32'(in_ready), 0);
         step();
      end
      out_ready = 1'b1;
      chk("bp_in_ready_at_handshake", 32'(in_ready), 0);
      step();
      chk("bp_in_ready_after", 32'(in_ready), 1);
      chk("bp_out_valid_after", 32'(out_valid), 0);

      bcd_in = 12'h777;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      step();
      chk("mid_busy", 32'(busy), 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_in_ready", 32'(in_ready), 1);
      chk("abort_out_valid", 32'(out_valid), 0);
      chk("abort_busy", 32'(busy), 0);
      run("c100", 12'h100, 100, 0, 11);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/dec3_to_bin_seq.md
Name: dec3_to_bin_seq

Overview:
Sequential BCD-to-binary converter. It is the inverse of the team's combinational binary-to-BCD block. It takes DIGITS packed decimal digits, for example a frequency or amplitude value entered on the keypad or UI, and produces an unsigned binary value for the DDS/scope control registers. It uses iterative reverse double-dabble: shift right, then subtract 3 from every nibble that is ≥8. Valid/ready handshake on both sides; one conversion in flight.

Parameters:
DIGITS, 3, number of BCD digits at input (most-significant digit in the top nibble).
BIN_W, 10, binary output width; also the number of shift iterations (10 covers 999).

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  bcd_in valid
in_ready  out  1  converter can accept a value
bcd_in  in  4*DIGITS  packed BCD, [4*DIGITS-1:4*DIGITS-4] = most-significant digit
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
bin_out  out  BIN_W  binary result
err_digit  out  1  an input nibble was >9
err_ovf  out  1  value does not fit in BIN_W bits
busy  out  1  conversion in progress (state ≠ IDLE)

Behaviour:
- Reset: the clock and reset are fixed as one clock `clk`, with `rst` synchronous and active-high.
  - State = IDLE, in_ready=1, out_valid=0, bin_out=0, err_digit=0, err_ovf=0, busy=0.
  - All internal registers are cleared.
- State machine, IDLE → SHIFT → DONE → IDLE:
  - IDLE: in_ready=1. On in_valid, capture bcd_in into the BCD half of a (4*DIGITS+BIN_W)-bit working register, clear the binary half, and clear the iteration counter.
    - If any captured nibble is >9: err_digit=1, bin_out=0, err_ovf=0, go directly to DONE (result valid 1 cycle after the accept edge).
    - Otherwise go to SHIFT.
  - SHIFT: one iteration per cycle.
    - Logically shift the whole register right by 1; the BCD LSB enters the binary MSB.
    - Then, for each BCD nibble of the shifted value, if the nibble is ≥8 subtract 3.
    - Both steps complete in the same cycle.
    - After BIN_W iterations go to DONE. Counter width is clog2(BIN_W+1).
  - DONE: out_valid=1.
    - bin_out = binary half of the register.
    - err_ovf = 1 if the residual BCD half is nonzero after BIN_W shifts.
    - Outputs hold stable while out_valid=1 and out_ready=0.
    - On out_ready, return to IDLE and drop out_valid the next cycle.
- Latency:
  - Legal input: out_valid asserts BIN_W+1 cycles after the accept edge (11 for the defaults).
  - Illegal digit: out_valid asserts 1 cycle after the accept edge.
- Throughput: one conversion per BIN_W+2 cycles minimum. in_ready=0 in SHIFT and DONE; no accept in the same cycle as an out handshake.
- err_digit and err_ovf are valid only while out_valid=1. They are cleared on the next accept.
- bin_out holds its last value in IDLE; its value there is not qualified.
- Overflow case: bin_out carries the low BIN_W bits of the true value, and err_ovf=1.
- rst mid-SHIFT or mid-DONE: abort immediately, return to reset values, emit no result.
- Reset has priority over every handshake.
- All arithmetic is unsigned. The nibble subtract never underflows, because the subtract is applied only when the nibble is ≥8.

Decomposition:
- Shared package: state encoding localparams (S_IDLE, S_SHIFT, S_DONE) and the constant BCD_ADJ = 4'd3.
- Sub-module bcd_nibble_adj: 4-bit combinational unit, out = (in ≥ 8) ? in−3 : in.
  - Instantiated DIGITS times in a generate loop on the post-shift BCD field.
- Everything else is flat: FSM, counter and working register.

Test Plan:
- bcd_in=12'h255, out_ready=1 → out_valid 11 cycles after accept; bin_out=10'd255; both error flags 0.
- bcd_in=12'h999 → bin_out=10'd999 (0x3E7). bcd_in=12'h000 → bin_out=0. Both with no flags.
- bcd_in=12'h1A3 → out_valid 1 cycle after accept, err_digit=1, bin_out=0.
- Parameter BIN_W=8, bcd_in=12'h256 → err_ovf=1, bin_out=8'h00. With bcd_in=12'h255 → err_ovf=0, bin_out=8'hFF.
- Backpressure: bcd_in=12'h042, out_ready held 0 for 5 cycles → out_valid, bin_out=42 and flags stable throughout; in_ready=0 until one cycle after out_ready.
- Assert rst for 1 cycle at iteration 4 → next cycle in_ready=1, out_valid=0, busy=0. A following conversion of 12'h100 returns 100.
